hc595_chain_ctrl: RTL

HC595_CHAIN_CTRL -- requirements
Module: hc595_chain_ctrl

---
 rtl/hc595_pkg.sv | 15 +
 rtl/hc595_oe_pwm.sv | 30 +++
 rtl/hc595_chain_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
// hc595_pkg
//   Shared definitions for the 74HC595 chain controller:
//   controller state encoding and the output-enable PWM duty width.
package hc595_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

endpackage

// File: rtl/hc595_oe_pwm.sv
// hc595_oe_pwm
//   Registered active-low output-enable generator for a 595 chain.
//   Ports:
//     sys_clk, sys_rst : clock, synchronous active-high reset
//     pwm_cnt          : free-running phase counter from the controller
//     duty             : on-time in 1/256 steps (0 = off)
//     blank            : 1 forces the outputs disabled
//     frame_valid      : 1 once the chain holds a completely latched frame
//     oe_n             : registered output enable, low = outputs driven
module hc595_oe_pwm
    import hc595_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty,
    input  logic              blank,
    input  logic              frame_valid,
    output logic              oe_n
);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            oe_n <= 1'b1;
        end else begin
            oe_n <= ~(frame_valid & ~blank & (pwm_cnt < duty));
        end
    end

endmodule

// File: rtl/hc595_chain_ctrl.sv
// hc595_chain_ctrl
//   Serialises an N_BITS frame into a daisy-chain of 74HC595 shift
//   registers, pulses the storage clock, and drives a PWM output enable.
//   Parameters:
//     N_BITS    : bits per frame (2..64)
//     CLK_DIV   : sys_clk cycles per shcp half-period (1..255)
//     LSB_FIRST : 1 shifts data_in[0] first, 0 shifts data_in[N_BITS-1] first
//   Ports:
//     sys_clk, sys_rst : clock, synchronous active-high reset
//     data_in, load    : frame and request; accepted when load & ready
//     blank, duty      : output-enable control
//     ready, done      : idle flag, one-cycle frame-complete pulse
//     ds, shcp, stcp   : serial data, shift clock, storage clock
//     oe_n             : active-low output enable
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int N_BITS    = 14,
    parameter int CLK_DIV   = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_BITS-1:0] data_in,
    input  logic              load,
    input  logic              blank,
    input  logic [DUTY_W-1:0] duty,
    output logic              ready,
    output logic              done,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe_n
);

    localparam int                CNT_W    = $clog2(N_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(N_BITS - 1);
    localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);

    state_t              state;
    state_t              state_nx;
    logic [7:0]          div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nx;
    logic [N_BITS-1:0]   sreg;
    logic [N_BITS-1:0]   sreg_nx;
    logic                ds_nx;
    logic                half_done;
    logic                frame_valid;
    logic [DUTY_W-1:0]   pwm_cnt;

    assign half_done = (div_cnt == DIV_LAST);
    assign ds_nx     = LSB_FIRST ? sreg_nx[0] : sreg_nx[N_BITS-1];

    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx   = SHIFT_LO;
                    sreg_nx    = data_in;
                    bit_cnt_nx = '0;
                end
            end
            SHIFT_LO: begin
                if (half_done) state_nx = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (half_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = LATCH;
                    end else begin
                        state_nx   = SHIFT_LO;
                        bit_cnt_nx = bit_cnt + CNT_W'(1);
                        sreg_nx    = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
                    end
                end
            end
            LATCH: begin
                if (half_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they line up with
    // the state register; ds only moves on the same edge shcp falls.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            ds          <= 1'b0;
            shcp        <= 1'b0;
            stcp        <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            frame_valid <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            bit_cnt <= bit_cnt_nx;
            div_cnt <= (state_nx != state || state == IDLE) ? 8'd0 : div_cnt + 8'd1;
            ds      <= (state_nx == SHIFT_LO || state_nx == SHIFT_HI) ? ds_nx : 1'b0;
            shcp    <= (state_nx == SHIFT_HI);
            stcp    <= (state_nx == LATCH);
            ready   <= (state_nx == IDLE);
            done    <= (state == LATCH) && (state_nx == IDLE);
            if (state == LATCH && state_nx == IDLE) frame_valid <= 1'b1;
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

    hc595_oe_pwm u_oe_pwm (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .pwm_cnt     (pwm_cnt),
        .duty        (duty),
        .blank       (blank),
        .frame_valid (frame_valid),
        .oe_n        (oe_n)
    );

endmodule
